// File: rtl/bram_16384x1_port_arbiter_pkg.sv
// Shared constants and types for the 16384x1 BRAM port arbiter.
package bram_16384x1_port_arbiter_pkg;

    localparam int BRAM_AW    = 14;     // address width of the 16384-entry array
    localparam int BRAM_DEPTH = 16384;  // number of one-bit entries
    localparam int CLEAR_LEN  = 8192;   // clear cycles: two entries per cycle
    localparam int CNT_W      = 13;     // clear counter width, log2(CLEAR_LEN)

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/bram_16384x1_port_arbiter_rr_pick2.sv
// Round-robin scan that returns the first two valid requesters at or after ptr.
module bram_16384x1_port_arbiter_rr_pick2 #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx0,
    output logic            found0,
    output logic [IW-1:0]   idx1,
    output logic            found1
);

    // Walk the requesters in order ptr, ptr+1, ... (mod NREQ) and keep the first two hits.
    always_comb begin : scan
        int j;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx0   = '0;
        found0 = 1'b0;
        idx1   = '0;
        found1 = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (valid[j]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    idx0   = IW'(j);
                end else if (!found1) begin
                    found1 = 1'b1;
                    idx1   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bram_16384x1_port_arbiter.sv
// Shares both ports of the 16384x1 dual-port BRAM among NREQ requesters,
// routes read responses back, and zeroes the array after reset or on command.
module bram_16384x1_port_arbiter
    import bram_16384x1_port_arbiter_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int AW             = BRAM_AW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_start,
    output logic             busy,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_d,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ-1:0]    rsp_q,
    output logic [AW-1:0]    a0,
    output logic             d0,
    output logic             we0,
    output logic             wem0,
    output logic             ce0,
    input  logic             q0,
    output logic [AW-1:0]    a1,
    output logic             d1,
    output logic             we1,
    output logic             wem1,
    output logic             ce1,
    input  logic             q1
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IW-1:0]     ptr;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [NREQ-1:0]   rsp_port_q;   // 1 = the pending response comes from port 1

    logic [IW-1:0]     idx0, idx1;
    logic              found0, found1;
    logic [AW-1:0]     cand_addr0, cand_addr1;
    logic              collide;
    logic              arb_en;
    logic              grant0, grant1;
    logic [NREQ-1:0]   rd_grant;
    logic [NREQ-1:0]   rd_port1;
    logic [IW-1:0]     last_idx;
    logic [IW-1:0]     next_ptr;

    assign wem0 = 1'b1;
    assign wem1 = 1'b1;
    assign busy = (state == ST_CLEAR);

    bram_16384x1_port_arbiter_rr_pick2 #(
        .NREQ (NREQ)
    ) u_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .idx0   (idx0),
        .found0 (found0),
        .idx1   (idx1),
        .found1 (found1)
    );

    // Grant selection: two round-robin candidates, second dropped on an address collision with a write.
    always_comb begin
        cand_addr0 = req_addr[int'(idx0)*AW +: AW];
        cand_addr1 = req_addr[int'(idx1)*AW +: AW];
        collide    = found1 && (cand_addr0 == cand_addr1) && (req_we[idx0] || req_we[idx1]);
        arb_en     = rst_n && (state == ST_RUN);
        grant0     = arb_en && found0;
        grant1     = arb_en && found1 && !collide;

        req_ready = '0;
        rd_grant  = '0;
        rd_port1  = '0;
        if (grant0) begin
            req_ready[idx0] = 1'b1;
            rd_grant[idx0]  = !req_we[idx0];
        end
        if (grant1) begin
            req_ready[idx1] = 1'b1;
            rd_grant[idx1]  = !req_we[idx1];
            rd_port1[idx1]  = 1'b1;
        end

        last_idx = grant1 ? idx1 : idx0;
        next_ptr = (last_idx == IW'(NREQ - 1)) ? '0 : last_idx + 1'b1;
    end

    // BRAM port drive: idle in reset, sweep both halves while clearing, granted requesters otherwise.
    always_comb begin
        a0  = '0;  d0 = 1'b0;  we0 = 1'b0;  ce0 = 1'b0;
        a1  = '0;  d1 = 1'b0;  we1 = 1'b0;  ce1 = 1'b0;
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                a0  = AW'({1'b0, cnt});
                a1  = AW'({1'b1, cnt});
                ce0 = 1'b1;
                ce1 = 1'b1;
                we0 = 1'b1;
                we1 = 1'b1;
            end else begin
                if (grant0) begin
                    a0  = cand_addr0;
                    d0  = req_d[idx0];
                    we0 = req_we[idx0];
                    ce0 = 1'b1;
                end
                if (grant1) begin
                    a1  = cand_addr1;
                    d1  = req_d[idx1];
                    we1 = req_we[idx1];
                    ce1 = 1'b1;
                end
            end
        end
    end

    // Mode FSM and clear counter: RUN arbitrates, CLEAR sweeps 8192 cycles then returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                ST_RUN: begin
                    if (clear_start) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == CNT_W'(CLEAR_LEN - 1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Round-robin pointer and one-cycle read-response bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            rsp_valid_q <= '0;
            rsp_port_q  <= '0;
        end else begin
            if (grant0) ptr <= next_ptr;
            rsp_valid_q <= rd_grant;
            rsp_port_q  <= rd_port1;
        end
    end

    // The BRAM output is already registered, so the response bit is a gated mux of Q0/Q1.
    always_comb begin
        rsp_valid = rsp_valid_q;
        for (int i = 0; i < NREQ; i++) begin
            rsp_q[i] = rsp_valid_q[i] & (rsp_port_q[i] ? q1 : q0);
        end
    end

endmodule

// File: tb/tb_bram_16384x1_port_arbiter.sv
// Directed bench for bram_16384x1_port_arbiter with a behavioural read-first BRAM.
module tb_bram_16384x1_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear_start;
    logic              busy;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   req_d;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_q;
    logic [AW-1:0]     a0, a1;
    logic              d0, we0, wem0, ce0, d1, we1, wem1, ce1;
    logic              q0 = 1'b0;
    logic              q1 = 1'b0;

    logic              mem [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_16384x1_port_arbiter #(
        .NREQ (NREQ), .AW (AW), .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .clear_start (clear_start), .busy (busy),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_d (req_d),
        .rsp_valid (rsp_valid), .rsp_q (rsp_q),
        .a0 (a0), .d0 (d0), .we0 (we0), .wem0 (wem0), .ce0 (ce0), .q0 (q0),
        .a1 (a1), .d1 (d1), .we1 (we1), .wem1 (wem1), .ce1 (ce1), .q1 (q1)
    );

    // Behavioural dual-port BRAM, read-first, registered outputs.
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) mem[a0] <= d0;
            q0 <= mem[a0];
        end
        if (ce1) begin
            if (we1) mem[a1] <= d1;
            q1 <= mem[a1];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr, input logic d);
        req_we[i]            = we;
        req_addr[i*AW +: AW] = addr;
        req_d[i]             = d;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int bad_busy, bad_addr, bad_ctl, bad_rdy, busy_cnt;
        logic done;

        rst_n       = 1'b0;
        clear_start = 1'b0;
        req_valid   = '1;
        req_we      = '0;
        req_addr    = '0;
        req_d       = '0;

        // Reset state
        repeat (3) cyc();
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_ce",    32'({ce1, ce0}), 32'h0);
        check("rst_we",    32'({we1, we0}), 32'h0);
        check("rst_rsp",   32'({rsp_valid, rsp_q}), 32'h0);
        check("wem",       32'({wem1, wem0}), 32'h3);

        // Clear after reset release: 8192 busy cycles sweeping both halves.
        rst_n = 1'b1;
        bad_busy = 0; bad_addr = 0; bad_ctl = 0; bad_rdy = 0;
        for (int i = 0; i < 8192; i++) begin
            if (i > 0) cyc();
            #1;
            if (busy !== 1'b1) bad_busy++;
            if (a0 !== AW'(i) || a1 !== AW'(i + 8192)) bad_addr++;
            if ({ce0, ce1, we0, we1, d0, d1} !== 6'b111100) bad_ctl++;
            if (req_ready !== '0) bad_rdy++;
        end
        check("clr_busy_cycles", 32'(bad_busy), 32'h0);
        check("clr_addr_steps",  32'(bad_addr), 32'h0);
        check("clr_port_ctl",    32'(bad_ctl),  32'h0);
        check("clr_ready_low",   32'(bad_rdy),  32'h0);
        check("clr_last_a1",     32'(a1), 32'd16383);
        cyc(); #1;
        check("clr_done_busy", 32'(busy), 32'h0);

        // Write req0 @5 = 1, then read it back via req2.
        cyc(); req_valid = 4'b0001; set_req(0, 1'b1, 14'h0005, 1'b1); #1;
        check("wr_ready", 32'(req_ready), 32'h1);
        check("wr_port0", 32'({ce0, we0, d0, a0}), 32'({3'b111, 14'h0005}));
        check("wr_ce1",   32'(ce1), 32'h0);
        cyc(); req_valid = 4'b0100; set_req(2, 1'b0, 14'h0005, 1'b0); #1;
        check("rd_ready", 32'(req_ready), 32'h4);
        check("rd_port0", 32'({ce0, we0, a0}), 32'({2'b10, 14'h0005}));
        cyc(); req_valid = '0; #1;
        check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
        check("rd_rsp_q",     32'(rsp_q), 32'h4);
        cyc(); #1;
        check("rd_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Pointer now 3: grant req3 alone so the next scan starts at 0.
        cyc(); req_valid = 4'b1000; set_req(3, 1'b0, 14'h0020, 1'b0); #1;
        check("rr_pre_ready", 32'(req_ready), 32'h8);
        // All four valid reads: req0/req1 read 0x5 (holds 1), req2/req3 read cleared addresses.
        cyc(); req_valid = 4'b1111;
        set_req(0, 1'b0, 14'h0005, 1'b0); set_req(1, 1'b0, 14'h0005, 1'b0);
        set_req(2, 1'b0, 14'h0012, 1'b0); set_req(3, 1'b0, 14'h0013, 1'b0); #1;
        check("rr_c1_ready", 32'(req_ready), 32'h3);
        check("rr_c1_port1", 32'({ce1, a1}), 32'({1'b1, 14'h0005}));
        check("rr_c1_rsp",   32'({rsp_valid, rsp_q}), 32'h80);
        cyc(); #1;
        check("rr_c2_ready", 32'(req_ready), 32'hC);
        check("rr_c2_rsp",   32'({rsp_valid, rsp_q}), 32'h33);
        cyc(); #1;
        check("rr_c3_ready", 32'(req_ready), 32'h3);
        check("rr_c3_rsp",   32'({rsp_valid, rsp_q}), 32'hC0);
        cyc(); req_valid = '0; #1;
        check("rr_c4_rsp",   32'({rsp_valid, rsp_q}), 32'h33);

        // Pointer now 2: grant req0 alone to move it to 1.
        cyc(); req_valid = 4'b0001; set_req(0, 1'b0, 14'h0020, 1'b0); #1;
        check("col_pre_ready", 32'(req_ready), 32'h1);
        // Collision: req1 writes 0x1234, req2 reads 0x1234.
        cyc(); req_valid = 4'b0110;
        set_req(1, 1'b1, 14'h1234, 1'b1); set_req(2, 1'b0, 14'h1234, 1'b0); #1;
        check("col_ready", 32'(req_ready), 32'h2);
        check("col_port1_idle", 32'({ce1, we1}), 32'h0);
        check("col_port0", 32'({ce0, we0, d0, a0}), 32'({3'b111, 14'h1234}));
        cyc(); req_valid = 4'b0100; #1;
        check("col_next_ready", 32'(req_ready), 32'h4);
        cyc(); req_valid = '0; #1;
        check("col_rsp", 32'({rsp_valid, rsp_q}), 32'h44);

        // Read grant coinciding with clear_start (pointer 3 -> req1 found first).
        cyc(); req_valid = 4'b0010; set_req(1, 1'b0, 14'h1234, 1'b0); clear_start = 1'b1; #1;
        check("cs_ready", 32'(req_ready), 32'h2);
        check("cs_busy_low", 32'(busy), 32'h0);
        cyc(); req_valid = '0; clear_start = 1'b0; #1;
        check("cs_busy_high", 32'(busy), 32'h1);
        check("cs_rsp", 32'({rsp_valid, rsp_q}), 32'h22);
        check("cs_a0_start", 32'(a0), 32'h0);
        busy_cnt = 1;
        done = 1'b0;
        for (int k = 0; k < 9000; k++) begin
            cyc();
            clear_start = (k == 50);
            #1;
            if (busy === 1'b1) busy_cnt++;
            else begin done = 1'b1; break; end
        end
        clear_start = 1'b0;
        check("cs_clear_done", 32'(done), 32'h1);
        check("cs_clear_len", 32'(busy_cnt), 32'd8192);

        // The earlier write at 0x5 must be gone after the clear.
        cyc(); req_valid = 4'b0001; set_req(0, 1'b0, 14'h0005, 1'b0); #1;
        check("post_clr_ready", 32'(req_ready), 32'h1);
        cyc(); req_valid = '0; #1;
        check("post_clr_rsp", 32'({rsp_valid, rsp_q}), 32'h10);

        // Reset in the middle of a clear restarts it at cnt 0.
        cyc(); clear_start = 1'b1; #1;
        cyc(); clear_start = 1'b0; #1;
        check("rc_start_a0", 32'({busy, a0}), 32'({1'b1, 14'h0}));
        repeat (100) cyc();
        #1;
        check("rc_a0_100", 32'(a0), 32'd100);
        req_valid = 4'b1111;
        rst_n = 1'b0; #1;
        check("rc_rst_ctl", 32'({ce0, ce1, we0, we1}), 32'h0);
        check("rc_rst_ready", 32'(req_ready), 32'h0);
        cyc(); #1;
        check("rc_rst_rsp", 32'({rsp_valid, rsp_q, ce0, ce1}), 32'h0);
        req_valid = '0;
        rst_n = 1'b1; #1;
        check("rc_restart", 32'({busy, ce0, a0}), 32'({2'b11, 14'h0}));
        check("rc_restart_a1", 32'(a1), 32'd8192);
        cyc(); #1;
        check("rc_step", 32'(a0), 32'd1);
        done = 1'b0;
        for (int k = 0; k < 9000; k++) begin
            cyc(); #1;
            if (busy !== 1'b1) begin done = 1'b1; break; end
        end
        check("rc_clear_done", 32'(done), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
